// File: rtl/fir_filter_stage_if.sv
// fir_filter_stage_if: AXI-Stream-style input and output channels of one
// FIR phase branch. The filter takes the slave view and the upstream and
// downstream logic take the master view.
interface fir_filter_stage_if #(
   parameter int DATA_IN_WIDTH  = 16,
   parameter int DATA_OUT_WIDTH = 16
);
   logic [DATA_IN_WIDTH-1:0]  data_in_tdata;
   logic                      data_in_tvalid;
   logic                      data_in_tlast;
   logic                      data_in_tready;
   logic [DATA_OUT_WIDTH-1:0] data_out_tdata;
   logic                      data_out_tvalid;
   logic                      data_out_tlast;
   logic                      data_out_tready;

   modport master (
      output data_in_tdata, data_in_tvalid, data_in_tlast, data_out_tready,
      input  data_in_tready, data_out_tdata, data_out_tvalid, data_out_tlast
   );

   modport slave (
      input  data_in_tdata, data_in_tvalid, data_in_tlast, data_out_tready,
      output data_in_tready, data_out_tdata, data_out_tvalid, data_out_tlast
   );
endinterface

// File: rtl/fir_filter_stage.sv
// fir_filter_stage: fully parallel direct-form FIR phase branch.
// y[n] = sum c[k]*x[n-k]. The result is registered with one cycle of latency.
// A packet end (tlast) flushes zeros through the delay line, so each sample's
// full impulse response reaches the output.
// Build option: define OUT_SATURATE_EN to clamp the output. When it is not
// defined, the output wraps in two's complement.
module fir_filter_stage #(
   parameter int NUMBER_TAPS       = 4,
   parameter int DATA_IN_WIDTH     = 16,
   parameter int COEFFICIENT_WIDTH = 16,
   parameter int DATA_OUT_WIDTH    = 16,
   localparam int CA_W = (NUMBER_TAPS > 1) ? $clog2(NUMBER_TAPS) : 1
) (
   input  logic                          clock,
   input  logic                          reset,
   fir_filter_stage_if.slave             stream,
   output logic                          samples_remaining,
   input  logic                          coeffs_wren,
   input  logic [CA_W-1:0]               coeffs_addr,
   input  logic [COEFFICIENT_WIDTH-1:0]  coeffs_wdata
);
   localparam int PROD_W = DATA_IN_WIDTH + COEFFICIENT_WIDTH;
   localparam int ACC_W  = PROD_W + $clog2(NUMBER_TAPS);
   localparam int TAPS_D = (NUMBER_TAPS > 1) ? NUMBER_TAPS - 1 : 1;

   typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

   state_t                               state_r, state_nxt_s;
   logic [CA_W-1:0]                      cnt_r, cnt_nxt_s;
   logic                                 sr_r, sr_nxt_s;
   logic signed [COEFFICIENT_WIDTH-1:0]  coeffs_r [NUMBER_TAPS];
   logic signed [DATA_IN_WIDTH-1:0]      taps_r [TAPS_D];
   logic [DATA_OUT_WIDTH-1:0]            out_data_r;
   logic                                 out_valid_r;
   logic                                 out_last_r;

   logic                                 out_free_s;
   logic                                 in_ready_s;
   logic                                 in_xfer_s;
   logic                                 flush_step_s;
   logic                                 accept_last_s;
   logic                                 load_s;
   logic                                 clear_s;
   logic                                 last_nxt_s;
   logic signed [DATA_IN_WIDTH-1:0]      newest_s;
   logic signed [ACC_W-1:0]              acc_s;
   logic signed [ACC_W-1:0]              shifted_s;
   logic [DATA_OUT_WIDTH-1:0]            out_data_s;

   // Full-precision signed product of one sample and one coefficient.
   function automatic logic signed [PROD_W-1:0] mul_f(
      input logic signed [DATA_IN_WIDTH-1:0]     a,
      input logic signed [COEFFICIENT_WIDTH-1:0] b
   );
      mul_f = PROD_W'(a) * PROD_W'(b);
   endfunction

   assign out_free_s    = !out_valid_r || stream.data_out_tready;
   assign in_ready_s    = (state_r == RUN) && out_free_s;
   assign in_xfer_s     = stream.data_in_tvalid && in_ready_s;
   assign flush_step_s  = (state_r == FLUSH) && out_free_s && (cnt_r != {CA_W{1'b0}});
   assign accept_last_s = (state_r == FLUSH) && out_valid_r && out_last_r && stream.data_out_tready;

   assign stream.data_in_tready   = in_ready_s;
   assign stream.data_out_tdata   = out_data_r;
   assign stream.data_out_tvalid  = out_valid_r;
   assign stream.data_out_tlast   = out_last_r;
   assign samples_remaining       = sr_r;

   // Coefficient bank: written at runtime, not cleared by reset.
   always_ff @(posedge clock) begin
      if (coeffs_wren) begin
         for (int k = 0; k < NUMBER_TAPS; k++) begin
            if (coeffs_addr == CA_W'(k)) begin
               coeffs_r[k] <= coeffs_wdata;
            end
         end
      end
   end

   // FSM state, flush counter and flush-in-progress flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= RUN;
         cnt_r   <= {CA_W{1'b0}};
         sr_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         sr_r    <= sr_nxt_s;
      end
   end

   // Next state: accept samples in RUN, inject zeros in FLUSH.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      sr_nxt_s    = sr_r;
      load_s      = 1'b0;
      clear_s     = 1'b0;
      last_nxt_s  = 1'b0;
      newest_s    = {DATA_IN_WIDTH{1'b0}};
      case (state_r)
         RUN: begin
            if (in_xfer_s) begin
               load_s   = 1'b1;
               newest_s = $signed(stream.data_in_tdata);
               if ((NUMBER_TAPS > 1) && stream.data_in_tlast) begin
                  state_nxt_s = FLUSH;
                  cnt_nxt_s   = CA_W'(NUMBER_TAPS - 1);
                  sr_nxt_s    = 1'b1;
               end else begin
                  last_nxt_s = (NUMBER_TAPS == 1) ? stream.data_in_tlast : 1'b0;
               end
            end else begin
               load_s = 1'b0;
            end
         end
         FLUSH: begin
            if (flush_step_s) begin
               load_s     = 1'b1;
               cnt_nxt_s  = cnt_r - CA_W'(1);
               last_nxt_s = (cnt_r == CA_W'(1));
            end else if (accept_last_s) begin
               state_nxt_s = RUN;
               cnt_nxt_s   = {CA_W{1'b0}};
               sr_nxt_s    = 1'b0;
               clear_s     = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         default: begin
            state_nxt_s = RUN;
         end
      endcase
   end

   // Multiply-accumulate over the newest sample and the delay line.
   always_comb begin
      acc_s = ACC_W'(mul_f(newest_s, coeffs_r[0]));
      for (int k = 1; k < NUMBER_TAPS; k++) begin
         acc_s = acc_s + ACC_W'(mul_f(taps_r[k-1], coeffs_r[k]));
      end
      shifted_s = acc_s >>> (COEFFICIENT_WIDTH - 1);
   end

`ifdef OUT_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX_C =
      {{(ACC_W-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN_C =
      {{(ACC_W-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};

   // Clamp the scaled result into the output range.
   always_comb begin
      if (shifted_s > SAT_MAX_C) begin
         out_data_s = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
      end else if (shifted_s < SAT_MIN_C) begin
         out_data_s = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};
      end else begin
         out_data_s = DATA_OUT_WIDTH'(shifted_s);
      end
   end
`else
   // Keep the low bits of the scaled result (two's-complement wrap).
   always_comb begin
      out_data_s = DATA_OUT_WIDTH'(shifted_s);
   end
`endif

   // Delay line: shift on every produced output, clear once a flush completes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TAPS_D; i++) taps_r[i] <= {DATA_IN_WIDTH{1'b0}};
      end else if (clear_s) begin
         for (int i = 0; i < TAPS_D; i++) taps_r[i] <= {DATA_IN_WIDTH{1'b0}};
      end else if (load_s) begin
         taps_r[0] <= newest_s;
         for (int i = 1; i < TAPS_D; i++) taps_r[i] <= taps_r[i-1];
      end
   end

   // Output register: load on a new result, hold under backpressure.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_data_r  <= {DATA_OUT_WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else if (load_s) begin
         out_data_r  <= out_data_s;
         out_valid_r <= 1'b1;
         out_last_r  <= last_nxt_s;
      end else if (stream.data_out_tready) begin
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fir_filter_stage.sv
// tb_fir_filter_stage: directed scoreboard bench for fir_filter_stage.
// Test cases push the expected outputs into a queue. A negedge monitor pops
// one entry for each output that is accepted and compares it.
module tb_fir_filter_stage;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        samples_remaining;
   logic        coeffs_wren = 1'b0;
   logic [1:0]  coeffs_addr = 2'd0;
   logic [15:0] coeffs_wdata = 16'd0;

   int n_vec = 0;
   int n_err = 0;
   logic [16:0] exp_q [$];
   logic [16:0] mon_e;

   fir_filter_stage_if #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16)) s_if ();

   fir_filter_stage #(
      .NUMBER_TAPS(4), .DATA_IN_WIDTH(16), .COEFFICIENT_WIDTH(16), .DATA_OUT_WIDTH(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .stream(s_if.slave),
      .samples_remaining(samples_remaining),
      .coeffs_wren(coeffs_wren),
      .coeffs_addr(coeffs_addr),
      .coeffs_wdata(coeffs_wdata)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   // Scoreboard monitor: compare every accepted output against the queue head.
   always @(negedge clock) begin
      if (!reset && s_if.data_out_tvalid && s_if.data_out_tready) begin
         n_vec++;
         assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_output: observed 0x%0h expected none", s_if.data_out_tdata);
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("out_data", {16'd0, s_if.data_out_tdata}, {16'd0, mon_e[15:0]});
            check("out_last", {31'd0, s_if.data_out_tlast}, {31'd0, mon_e[16]});
         end
      end
   end

   task automatic write_coeff(input logic [1:0] a, input logic [15:0] v);
      coeffs_wren = 1'b1; coeffs_addr = a; coeffs_wdata = v;
      @(posedge clock); #1;
      coeffs_wren = 1'b0;
   endtask

   // Drive one sample and hold it until the DUT takes it (bounded wait).
   task automatic send(input logic [15:0] d, input logic l);
      bit done = 1'b0;
      s_if.data_in_tdata = d; s_if.data_in_tvalid = 1'b1; s_if.data_in_tlast = l;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clock);
         if (s_if.data_in_tready) done = 1'b1;
      end
      check("send_accepted", {31'd0, done}, 32'd1);
      @(posedge clock); #1;
   endtask

   task automatic idle();
      s_if.data_in_tvalid = 1'b0; s_if.data_in_tlast = 1'b0; s_if.data_in_tdata = 16'd0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clock);
      #1;
      check("drain_queue_empty", exp_q.size(), 32'd0);
      @(posedge clock); #1;
   endtask

   task automatic base_coeffs();
      write_coeff(2'd0, 16'h4000);
      write_coeff(2'd1, 16'h2000);
      write_coeff(2'd2, 16'h0000);
      write_coeff(2'd3, 16'h0000);
   endtask

   initial begin
      bit fin;
      s_if.data_out_tready = 1'b1;
      idle();
      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_tvalid", {31'd0, s_if.data_out_tvalid}, 32'd0);
      check("rst_tlast",  {31'd0, s_if.data_out_tlast}, 32'd0);
      check("rst_tdata",  {16'd0, s_if.data_out_tdata}, 32'd0);
      check("rst_sr",     {31'd0, samples_remaining}, 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;
      check("rst_in_tready", {31'd0, s_if.data_in_tready}, 32'd1);
      base_coeffs();

      // Impulse, full throughput
      push(16'd500, 1'b0); push(16'd250, 1'b0); push(16'd0, 1'b0); push(16'd0, 1'b0);
      send(16'd1000, 1'b0);
      check("latency_valid", {31'd0, s_if.data_out_tvalid}, 32'd1);
      check("latency_data",  {16'd0, s_if.data_out_tdata}, 32'd500);
      send(16'd0, 1'b0); send(16'd0, 1'b0); send(16'd0, 1'b0);
      idle();
      drain();

      // Backpressure
      push(16'd500, 1'b0); push(16'd250, 1'b0); push(16'd0, 1'b0); push(16'd0, 1'b0);
      send(16'd1000, 1'b0);
      s_if.data_out_tready = 1'b0;
      s_if.data_in_tdata = 16'd0; s_if.data_in_tvalid = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("bp_in_tready", {31'd0, s_if.data_in_tready}, 32'd0);
         check("bp_tvalid",    {31'd0, s_if.data_out_tvalid}, 32'd1);
         check("bp_hold_data", {16'd0, s_if.data_out_tdata}, 32'd500);
      end
      @(posedge clock); #1;
      s_if.data_out_tready = 1'b1;
      send(16'd0, 1'b0); send(16'd0, 1'b0); send(16'd0, 1'b0);
      idle();
      drain();

      // Flush on tlast
      push(16'd500, 1'b0); push(16'd250, 1'b0); push(16'd0, 1'b0); push(16'd0, 1'b1);
      send(16'd1000, 1'b1);
      idle();
      fin = 1'b0;
      for (int i = 0; i < 20 && !fin; i++) begin
         @(negedge clock);
         check("flush_sr",        {31'd0, samples_remaining}, 32'd1);
         check("flush_in_tready", {31'd0, s_if.data_in_tready}, 32'd0);
         if (s_if.data_out_tvalid && s_if.data_out_tlast) fin = 1'b1;
      end
      check("flush_last_seen", {31'd0, fin}, 32'd1);
      @(posedge clock); #1;
      check("flush_done_sr",     {31'd0, samples_remaining}, 32'd0);
      check("flush_done_tready", {31'd0, s_if.data_in_tready}, 32'd1);
      drain();

      // Saturation / wrap
      for (int k = 0; k < 4; k++) write_coeff(2'(k), 16'h7FFF);
`ifdef OUT_SATURATE_EN
      push(16'h7FFE, 1'b0); push(16'h7FFF, 1'b0); push(16'h7FFF, 1'b0); push(16'h7FFF, 1'b0);
`else
      push(16'h7FFE, 1'b0); push(16'hFFFC, 1'b0); push(16'h7FFA, 1'b0); push(16'hFFF8, 1'b0);
`endif
      for (int k = 0; k < 4; k++) send(16'h7FFF, 1'b0);
      idle();
      drain();

      // Reset mid-flush
      base_coeffs();
      send(16'd1000, 1'b1);
      idle();
      s_if.data_out_tready = 1'b0;
      @(negedge clock);
      check("mid_flush_sr", {31'd0, samples_remaining}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check("async_rst_tvalid", {31'd0, s_if.data_out_tvalid}, 32'd0);
      check("async_rst_tlast",  {31'd0, s_if.data_out_tlast}, 32'd0);
      check("async_rst_sr",     {31'd0, samples_remaining}, 32'd0);
      exp_q.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      s_if.data_out_tready = 1'b1;
      push(16'd500, 1'b0); push(16'd250, 1'b0); push(16'd0, 1'b0); push(16'd0, 1'b0);
      send(16'd1000, 1'b0); send(16'd0, 1'b0); send(16'd0, 1'b0); send(16'd0, 1'b0);
      idle();
      drain();

      // Coefficient update between samples
      write_coeff(2'd0, 16'h2000);
      push(16'd250, 1'b0); push(16'd250, 1'b0); push(16'd0, 1'b0); push(16'd0, 1'b0);
      send(16'd1000, 1'b0); send(16'd0, 1'b0); send(16'd0, 1'b0); send(16'd0, 1'b0);
      idle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Watchdog against a stuck run.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/fir_filter_stage.md
Name: fir_filter_stage

Overview:
- Single-clock, fully parallel, direct-form FIR sub-filter with runtime-writable coefficients and AXI-Stream-style input and output.
- Used as one phase branch of the polyphase interpolator.
- On a packet end (tlast), it flushes its delay line with zeros so that every input sample's full impulse response reaches the output.

Parameters:
- NUMBER_TAPS, 4: number of taps and coefficient registers (>=1).
- DATA_IN_WIDTH, 16: signed input sample width.
- COEFFICIENT_WIDTH, 16: signed coefficient width, Q1.(COEFFICIENT_WIDTH-1) format.
- DATA_OUT_WIDTH, 16: signed output sample width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in_tdata  in  DATA_IN_WIDTH  signed input sample.
- data_in_tvalid  in  1  input sample valid.
- data_in_tlast  in  1  last sample of the packet.
- data_in_tready  out  1  block accepts the input sample.
- data_out_tdata  out  DATA_OUT_WIDTH  signed filtered sample.
- data_out_tvalid  out  1  output sample valid.
- data_out_tlast  out  1  final flushed output of the packet.
- data_out_tready  in  1  downstream accepts the output.
- samples_remaining  out  1  high while a flush is in progress.
- coeffs_wren  in  1  coefficient write strobe.
- coeffs_addr  in  max(1,$clog2(NUMBER_TAPS))  coefficient index k.
- coeffs_wdata  in  COEFFICIENT_WIDTH  coefficient value.

Behaviour:
- Filter equation: y[n] = sum over k=0..NUMBER_TAPS-1 of c[k]*x[n-k].
  - x[n] is the newest sample; the delay line holds x[n-1..n-NUMBER_TAPS+1].
- Arithmetic:
  - Full-precision signed accumulator of DATA_IN_WIDTH+COEFFICIENT_WIDTH+$clog2(NUMBER_TAPS) bits.
  - Arithmetic shift right by COEFFICIENT_WIDTH-1 (floor).
  - Reduce to DATA_OUT_WIDTH per OUT_SATURATE_EN.
- Coefficients:
  - On a clock edge with coeffs_wren=1, c[coeffs_addr] <= coeffs_wdata. Out-of-range addresses are ignored.
  - A new value is used from the next computed output.
  - Coefficients are NOT cleared by reset; they are undefined until written.
- Handshake:
  - In RUN state, data_in_tready = !data_out_tvalid | data_out_tready. In FLUSH state it is 0.
  - Transfer on an input edge with tvalid & tready: shift the sample into the delay line and register the output.
  - The result appears on data_out_tdata with data_out_tvalid=1 the next cycle (latency 1).
  - data_out_tdata, data_out_tvalid and data_out_tlast are held stable until data_out_tready=1.
  - A cycle with output accepted and a new input transfer is full throughput.
  - If the output is accepted with no new transfer, tvalid drops to 0.
- State machine, states RUN and FLUSH:
  - RUN: a transfer with data_in_tlast=1 and NUMBER_TAPS>1 goes to FLUSH. A flush counter is loaded with NUMBER_TAPS-1 and samples_remaining is set.
  - FLUSH: each time the output register is free (empty or being accepted), shift a zero into the delay line and produce an output, then decrement the counter.
  - The output produced when the counter reaches 1 carries data_out_tlast=1.
  - Acceptance of that tlast output clears the delay line and samples_remaining and returns to RUN.
- NUMBER_TAPS=1: input tlast passes straight through on the corresponding output; there is no FLUSH.
- data_out_tlast is 0 on all non-final outputs.
- Reset (asynchronous, any time including mid-flush):
  - Delay line cleared to 0, state = RUN, flush counter = 0.
  - data_out_tvalid=0, data_out_tlast=0, data_out_tdata=0, samples_remaining=0.
  - Coefficients retained.
- Simultaneous coefficient write and data transfer: the output uses the old coefficient value.

Optional Feature:
- OUT_SATURATE_EN defined: the shifted result is clamped to [-2^(DATA_OUT_WIDTH-1), 2^(DATA_OUT_WIDTH-1)-1].
- OUT_SATURATE_EN undefined: the shifted result is truncated to its low DATA_OUT_WIDTH bits (two's-complement wrap).

Test Plan:
- Setup for all scenarios: defaults; write c = {0x4000, 0x2000, 0, 0}.
- Impulse: inputs 1000, 0, 0, 0 with tready=1 -> outputs 500, 250, 0, 0, each one cycle after its input; tlast=0 throughout.
- Backpressure: hold data_out_tready=0 after the first output -> data_in_tready=0 and output held at 500; release -> stream resumes with no loss or duplication.
- Flush: single input 1000 with tlast=1 -> outputs 500, 250, 0, 0 with tlast only on the 4th; data_in_tready=0 and samples_remaining=1 until the 4th output is accepted.
- Saturation: all c=0x7FFF, four inputs 0x7FFF -> 4th output 0x7FFF with OUT_SATURATE_EN, 0xFFF8 without.
- Reset mid-flush: assert reset during FLUSH -> tvalid, tlast and samples_remaining=0 immediately; the next impulse 1000 gives 500 (coefficients retained, delay line zeroed).
- Coefficient update: write c[0]=0x2000 between samples -> the next impulse 1000 produces 250 first.
